// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit is held BPS_PARAM clocks; busy/done handshake lets the frame builder stream bytes.
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_state,
  output logic       tx_done,
  output logic       rs232_tx
);
  localparam int BPS_PARAM = CLK_FREQ / BAUD_RATE;
  localparam int CW        = (BPS_PARAM > 1) ? $clog2(BPS_PARAM) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          line_d, done_d, busy_d;
  logic          tick, last_stop;

  assign tick      = (baud_q == CW'(BPS_PARAM - 1));
  assign last_stop = (STOP_BITS == 1) || stop_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q     <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      rs232_tx <= 1'b1;
      tx_state <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      st_q     <= st_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      rs232_tx <= line_d;
      tx_state <= busy_d;
      tx_done  <= done_d;
    end
  end

  // Next state; the shift register drops one bit each time a data bit is put on the line.
  always_comb begin
    st_d   = st_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    stop_d = stop_q;
    sh_d   = sh_q;
    par_d  = par_q;
    if (st_q == S_IDLE) begin
      baud_d = '0;
      if (tx_start) begin
        st_d   = S_START;
        sh_d   = tx_data;
        par_d  = (PARITY == 1) ? ~^tx_data : ^tx_data;
        bit_d  = '0;
        stop_d = 1'b0;
      end
    end else begin
      baud_d = tick ? '0 : baud_q + 1'b1;
      if (tick) begin
        case (st_q)
          S_START: begin
            st_d = S_DATA;
            sh_d = sh_q >> 1;
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              st_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = sh_q >> 1;
            end
          end
          S_PAR:   st_d = S_STOP;
          S_STOP: begin
            if (last_stop) st_d = S_IDLE;
            else           stop_d = 1'b1;
          end
          default: st_d = S_IDLE;
        endcase
      end
    end
  end

  // Registered outputs: value the line and flags take at the coming edge.
  always_comb begin
    line_d = rs232_tx;
    done_d = 1'b0;
    busy_d = tx_state;
    if (st_q == S_IDLE) begin
      line_d = ~tx_start;
      busy_d = tx_start;
    end else if (tick) begin
      case (st_q)
        S_START: line_d = sh_q[0];
        S_DATA: begin
          if (bit_q == 3'd7) line_d = (PARITY != 0) ? par_q : 1'b1;
          else               line_d = sh_q[0];
        end
        S_PAR:   line_d = 1'b1;
        S_STOP: begin
          line_d = 1'b1;
          if (last_stop) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end
        end
        default: line_d = 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: four parity/stop configurations checked every cycle against a
// time-based frame model, literal frame checks, reset abort, and a behavioural loopback receiver.
module tb_uart_byte_tx;
  localparam int BPS = 10;
  localparam logic [7:0] PAR_V = {2'd2, 2'd1, 2'd2, 2'd0};
  localparam logic [7:0] STP_V = {2'd2, 2'd1, 2'd1, 2'd1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start = '0;
  logic [7:0] dat [4];
  wire  [3:0] line, st, dn;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_byte_tx #(.CLK_FREQ(1000), .BAUD_RATE(100),
                   .PARITY(int'(PAR_V[2*g +: 2])), .STOP_BITS(int'(STP_V[2*g +: 2]))) dut (
      .clk_in(clk), .rst_in(rst), .tx_start(start[g]), .tx_data(dat[g]),
      .tx_state(st[g]), .tx_done(dn[g]), .rs232_tx(line[g]));
  end

  function automatic int par_of(input int i);
    return int'(PAR_V[2*i +: 2]);
  endfunction
  function automatic int stp_of(input int i);
    return int'(STP_V[2*i +: 2]);
  endfunction

  // Frame as a bit list in line order: start, data LSB first, parity, then stop ones.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int p);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (p == 2)      f[9] = ^d;
    else if (p == 1) f[9] = ~^d;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: position inside a frame is elapsed clocks since acceptance.
  bit          act [4];
  int          t [4];
  int          nb [4];
  logic [11:0] fb [4];
  logic        e_line [4], e_st [4], e_dn [4];
  bit          started = 0, rx_kill = 0;
  logic [7:0]  sent_q [$];

  always @(posedge clk) begin
    started = 1;
    for (int i = 0; i < 4; i++) begin
      e_dn[i] = 1'b0;
      if (rst) begin
        if (i == 0 && act[0] && sent_q.size() > 0) void'(sent_q.pop_back());
        act[i] = 0;
      end else if (act[i]) begin
        t[i]++;
        if (t[i] == nb[i] * BPS) begin
          act[i]  = 0;
          e_dn[i] = 1'b1;
        end
      end else if (start[i]) begin
        act[i] = 1;
        t[i]   = 0;
        nb[i]  = 9 + int'(par_of(i) != 0) + stp_of(i);
        fb[i]  = frame_bits(dat[i], par_of(i));
        if (i == 0) sent_q.push_back(dat[i]);
      end
      e_st[i]   = act[i];
      e_line[i] = act[i] ? fb[i][t[i] / BPS] : 1'b1;
    end
    if (rst) rx_kill = 1;
  end

  // Per-cycle compare plus a mid-bit sampling receiver on instance 0.
  logic       prev_line = 1'b1;
  bit         rx_busy = 0;
  int         rx_cnt = 0, rx_n = 0;
  logic [7:0] rx_b = '0;

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("line%0d", i), line[i], e_line[i]);
        chk($sformatf("state%0d", i), st[i], e_st[i]);
        chk($sformatf("done%0d", i), dn[i], e_dn[i]);
      end
    end
    if (rx_kill) begin
      rx_busy = 0;
      rx_kill = 0;
    end else if (!rx_busy) begin
      if (prev_line && !line[0]) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > BPS && rx_cnt < 9 * BPS && rx_cnt % BPS == BPS / 2)
        rx_b[rx_cnt / BPS - 1] = line[0];
      if (rx_cnt == 9 * BPS + BPS / 2) begin
        rx_busy = 0;
        rx_n++;
        chk("rx_stop", line[0], 1);
        if (sent_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_extra: got byte %0h expected none", rx_b);
        end else begin
          chk("rx_byte", rx_b, sent_q.pop_front());
        end
      end
    end
    prev_line = line[0];
  end

  task automatic frame_lit(input int i, input logic [7:0] d, input logic [11:0] eb,
                           input int nbits, input int done_at);
    int first_done;
    first_done = -1;
    @(negedge clk);
    start[i] = 1'b1;
    dat[i]   = d;
    @(negedge clk);
    start[i] = 1'b0;
    dat[i]   = 8'($urandom);
    for (int c = 0; c <= done_at + 2; c++) begin
      if (c % BPS == BPS / 2 && c / BPS < nbits)
        chk($sformatf("lit%0d_bit%0d", i, c / BPS), line[i], eb[c / BPS]);
      if (dn[i] && first_done < 0) first_done = c;
      @(negedge clk);
    end
    chk($sformatf("lit%0d_done_at", i), first_done, done_at);
    chk($sformatf("lit%0d_idle_high", i), line[i], 1);
  endtask

  initial begin
    int cyc, base, seen;
    foreach (dat[i]) dat[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_line%0d", i), line[i], 1);
      chk($sformatf("rst_state%0d", i), st[i], 0);
      chk($sformatf("rst_done%0d", i), dn[i], 0);
    end
    rst = 1'b0;

    frame_lit(0, 8'h55, 12'h2AA, 10, 100);
    frame_lit(1, 8'h03, 12'h406, 11, 110);
    frame_lit(1, 8'h07, 12'h60E, 11, 110);
    frame_lit(2, 8'h03, 12'h606, 11, 110);
    frame_lit(3, 8'hFF, 12'hDFE, 12, 120);

    // Held tx_start with data changed mid-frame: next frame starts one idle clock after done.
    @(negedge clk);
    start[0] = 1'b1;
    dat[0]   = 8'h0F;
    @(negedge clk);
    for (int c = 0; c <= 101; c++) begin
      if (c == 35) dat[0] = 8'hAA;
      if (c == 100) begin
        chk("b2b_gap_line", line[0], 1);
        chk("b2b_done", dn[0], 1);
      end
      if (c == 101) begin
        chk("b2b_start_bit", line[0], 0);
        chk("b2b_state", st[0], 1);
        start[0] = 1'b0;
      end
      @(negedge clk);
    end
    repeat (110) @(negedge clk);

    // Reset mid-data aborts without tx_done.
    @(negedge clk);
    start[0] = 1'b1;
    dat[0]   = 8'h3C;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (46) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_line", line[0], 1);
    chk("abort_state", st[0], 0);
    rst = 1'b0;
    seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (dn[0]) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    frame_lit(0, 8'hA5, 12'h34A, 10, 100);

    // Random streaming on all instances until 256 bytes loop back through instance 0.
    base = rx_n;
    cyc  = 0;
    while (rx_n - base < 256 && cyc < 40000) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        start[i] = ($urandom_range(0, 3) != 0);
        dat[i]   = 8'($urandom);
      end
      cyc++;
    end
    start = '0;
    chk("rand_in_budget", int'(cyc < 40000), 1);
    repeat (150) @(negedge clk);
    chk("queue_drained", sent_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
